// File: rtl/srl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : srl_fifo
// Brief    : First-word-fall-through FIFO built on a dynamic-address shift
//            register array with a registered output stage (capacity D+1).
// Revision : 1.0 - initial release
// ============================================================================
module srl_fifo #(
    parameter int    NBITS     = 8,
    parameter string USE_SRL16 = "TRUE",
    localparam int   ADDR_BITS = (USE_SRL16 == "TRUE") ? 4 : 5,
    localparam int   D         = 1 << ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NBITS-1:0]     s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [NBITS-1:0]     m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [ADDR_BITS:0]   count
);

    localparam logic [ADDR_BITS:0] c_srl_full = (ADDR_BITS + 1)'(D);
    localparam logic [ADDR_BITS:0] c_one      = (ADDR_BITS + 1)'(1);

    logic [ADDR_BITS:0]   r_srl_cnt;
    logic                 r_ovalid;
    logic [NBITS-1:0]     r_m_tdata;
    logic [NBITS-1:0]     w_srl_q;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic                 w_push;
    logic                 w_load;

    // Ready depends only on registers and reset, never on the output side.
    assign s_tready  = !rst && (r_srl_cnt != c_srl_full);
    assign w_push    = s_tvalid && s_tready;
    assign w_load    = (r_srl_cnt != '0) && (!r_ovalid || m_tready);
    assign w_rd_addr = ADDR_BITS'(r_srl_cnt - c_one);

    // One shift register per data bit; shared enable and read address.
    for (genvar b = 0; b < NBITS; b++) begin : g_srl
        logic [D-1:0] r_sh;

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_sh <= {r_sh[D-2:0], s_tdata[b]};
            end
        end

        assign w_srl_q[b] = r_sh[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_srl_cnt <= '0;
            r_ovalid  <= 1'b0;
            r_m_tdata <= '0;
        end else begin
            if (w_load) begin
                r_m_tdata <= w_srl_q;
                r_ovalid  <= 1'b1;
            end else if (r_ovalid && m_tready) begin
                r_ovalid  <= 1'b0;
            end

            // Simultaneous push and load leaves the count unchanged: the shift
            // moves the next-oldest entry exactly onto the current read address.
            case ({w_push, w_load})
                2'b10:   r_srl_cnt <= r_srl_cnt + c_one;
                2'b01:   r_srl_cnt <= r_srl_cnt - c_one;
                default: r_srl_cnt <= r_srl_cnt;
            endcase
        end
    end

    assign m_tdata  = r_m_tdata;
    assign m_tvalid = r_ovalid;
    assign count    = r_srl_cnt + {{ADDR_BITS{1'b0}}, r_ovalid};

endmodule
`default_nettype wire

// File: tb/tb_srl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_srl_fifo
// Brief    : Self-checking bench for srl_fifo (SRL16 and SRLC32 variants).
// Revision : 1.0 - initial release
// ============================================================================
module tb_srl_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] s_tdata, m_tdata, b_s_tdata, b_m_tdata;
    logic       s_tvalid, s_tready, m_tvalid, m_tready;
    logic       b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tready;
    logic [4:0] count;
    logic [5:0] b_count;

    int total = 0;
    int bad   = 0;

    srl_fifo #(.NBITS(8), .USE_SRL16("TRUE")) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .count(count)
    );

    srl_fifo #(.NBITS(8), .USE_SRL16("FALSE")) dut32 (
        .clk(clk), .rst(rst),
        .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
        .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
        .count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: one reference queue per instance.
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
        end else begin
            if (m_tvalid && m_tready) begin
                chk("pop_nonempty16", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) chk("order16", m_tdata, q0.pop_front());
            end
            if (s_tvalid && s_tready) q0.push_back(s_tdata);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            q1.delete();
        end else begin
            if (b_m_tvalid && b_m_tready) begin
                chk("pop_nonempty32", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) chk("order32", b_m_tdata, q1.pop_front());
            end
            if (b_s_tvalid && b_s_tready) q1.push_back(b_s_tdata);
        end
    end

    always @(negedge clk) begin
        chk("count16", count, q0.size());
        chk("bound16", 32'(count <= 5'd17), 1);
        chk("count32", b_count, q1.size());
        chk("bound32", 32'(b_count <= 6'd33), 1);
    end

    typedef struct {
        logic       rst;
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       str;
        logic       mv;
        logic [7:0] md;
        logic [4:0] cnt;
    } vec_t;

    vec_t vt[15];

    initial begin
        int  v;
        int  sent;
        int  exp_w;
        int  gaps;
        int  orderbad;
        bit  acc;

        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
        b_s_tvalid = 1'b0; b_s_tdata = '0; b_m_tready = 1'b0;

        //          rst sv  sd     mr   str mv  md     cnt
        vt[0]  = '{1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,5'd0};
        vt[1]  = '{1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,5'd0};
        vt[2]  = '{1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,5'd0};
        vt[3]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,5'd0};
        vt[4]  = '{1'b0,1'b1,8'hA5,1'b0, 1'b1,1'b0,8'h00,5'd1};
        vt[5]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,1'b1,8'hA5,5'd1};
        vt[6]  = '{1'b0,1'b1,8'h11,1'b0, 1'b1,1'b1,8'hA5,5'd2};
        vt[7]  = '{1'b0,1'b1,8'h22,1'b0, 1'b1,1'b1,8'hA5,5'd3};
        vt[8]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h11,5'd2};
        vt[9]  = '{1'b0,1'b1,8'h33,1'b1, 1'b1,1'b1,8'h22,5'd2};
        vt[10] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h33,5'd1};
        vt[11] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h33,5'd0};
        vt[12] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h33,5'd0};
        vt[13] = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,5'd0};
        vt[14] = '{1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,5'd0};

        for (int i = 0; i < 15; i++) begin
            rst      = vt[i].rst;
            s_tvalid = vt[i].sv;
            s_tdata  = vt[i].sd;
            m_tready = vt[i].mr;
            step();
            chk($sformatf("vec%0d_s_tready", i), s_tready, vt[i].str);
            chk($sformatf("vec%0d_m_tvalid", i), m_tvalid, vt[i].mv);
            chk($sformatf("vec%0d_m_tdata", i),  m_tdata,  vt[i].md);
            chk($sformatf("vec%0d_count", i),    count,    vt[i].cnt);
        end
        s_tvalid = 1'b0; m_tready = 1'b0;

        // Fill with 0x00..0x20 offered continuously, no consumer.
        v = 0;
        for (int c = 0; c < 40; c++) begin
            s_tdata  = 8'(v);
            s_tvalid = (v <= 32);
            acc      = s_tvalid && s_tready;
            step();
            if (acc) v++;
        end
        s_tvalid = 1'b0;
        chk("fill_accepted", v, 17);
        chk("fill_s_tready", s_tready, 0);
        chk("fill_count", count, 17);

        m_tready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk("drain_m_tvalid", m_tvalid, 1);
            chk("drain_m_tdata", m_tdata, i);
            step();
        end
        m_tready = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_empty", m_tvalid, 0);

        // Two-cycle write-to-read latency on an empty FIFO.
        s_tvalid = 1'b1; s_tdata = 8'hA5;
        step();
        s_tvalid = 1'b0;
        chk("lat_n_m_tvalid", m_tvalid, 0);
        step();
        chk("lat_n1_m_tvalid", m_tvalid, 1);
        chk("lat_n1_m_tdata", m_tdata, 8'hA5);
        m_tready = 1'b1;
        step();

        // Sustained streaming: one word per cycle once primed.
        sent = 0; exp_w = 0; gaps = 0; orderbad = 0;
        for (int c = 0; c < 1010; c++) begin
            s_tvalid = (sent < 1000);
            s_tdata  = 8'(sent);
            acc      = s_tvalid && s_tready;
            if (m_tvalid) begin
                if (m_tdata !== 8'(exp_w)) orderbad++;
                exp_w++;
            end else if (c >= 2 && exp_w < 1000) begin
                gaps++;
            end
            step();
            if (acc) sent++;
        end
        s_tvalid = 1'b0; m_tready = 1'b0;
        chk("stream_popped", exp_w, 1000);
        chk("stream_gaps", gaps, 0);
        chk("stream_order", orderbad, 0);

        // Full boundary with simultaneous valid and ready.
        v = 0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 30 && s_tready; c++) begin
            s_tdata = 8'(8'h60 + v);
            step();
            v++;
        end
        chk("full_count", count, 17);
        s_tdata = 8'hEE; m_tready = 1'b1;
        chk("full_s_tready_low", s_tready, 0);
        step();
        m_tready = 1'b0;
        chk("full_pop_count", count, 16);
        chk("full_s_tready_back", s_tready, 1);
        step();
        s_tvalid = 1'b0;
        chk("full_refill_count", count, 17);
        m_tready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) chk("full_last_word", m_tdata, 8'hEE);
            step();
        end
        m_tready = 1'b0;
        chk("full_drained", count, 0);

        // Reset mid-operation flushes everything.
        s_tvalid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s_tdata = 8'(8'h50 + i);
            step();
        end
        s_tvalid = 1'b0;
        chk("mid_count_before", count, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_count_after", count, 0);
        chk("mid_m_tvalid_after", m_tvalid, 0);
        s_tvalid = 1'b1; s_tdata = 8'h3C;
        step();
        s_tvalid = 1'b0;
        step();
        chk("mid_first_valid", m_tvalid, 1);
        chk("mid_first_data", m_tdata, 8'h3C);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        chk("mid_empty", count, 0);

        // Random valid/backpressure on both depths.
        for (int c = 0; c < 10000; c++) begin
            s_tvalid   = 1'($urandom_range(0, 1));
            s_tdata    = 8'($urandom);
            m_tready   = 1'($urandom_range(0, 1));
            b_s_tvalid = 1'($urandom_range(0, 1));
            b_s_tdata  = 8'($urandom);
            b_m_tready = 1'($urandom_range(0, 1));
            step();
        end
        s_tvalid = 1'b0; b_s_tvalid = 1'b0;
        m_tready = 1'b0; b_m_tready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
